// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the decode/register-file stage and the multiply/divide unit.
// state_dbg mirrors the unit's FSM state for observation only.
interface mult_div_unit_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         hi_wen;
  logic         lo_wen;
  logic [N-1:0] wd;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [1:0]   state_dbg;

  // start is sampled only while busy is low; done pulses for exactly one cycle
  // and a new start may be presented in that same cycle.
  modport slave (
    input  start, op, inA, inB, hi_wen, lo_wen, wd,
    output busy, done, div_by_zero, hi, lo, state_dbg
  );

  modport master (
    output start, op, inA, inB, hi_wen, lo_wen, wd,
    input  busy, done, div_by_zero, hi, lo, state_dbg
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, N+1 clock latency.
// Define MDU_SIGNED_EN to make op[0] select signed mult/div; otherwise every operation is unsigned.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  mult_div_unit_if.slave        bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam int              CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic           is_div_q, is_div_d;
  logic           zero_div_q, zero_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic           signed_op;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_rem;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

`ifdef MDU_SIGNED_EN
  assign signed_op = bus.op[0];
`else
  assign signed_op = 1'b0;
`endif

  assign a_neg = signed_op & bus.inA[N-1];
  assign b_neg = signed_op & bus.inB[N-1];
  assign a_mag = a_neg ? -bus.inA : bus.inA;
  assign b_mag = b_neg ? -bus.inB : bus.inB;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? opnd_q : {N{1'b0}})};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = div_ge ? N'(div_shift - {1'b0, opnd_q}) : div_shift[N-1:0];

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    zero_div_d = zero_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d   = bus.op[1];
          zero_div_d = bus.op[1] && (bus.inB == {N{1'b0}});
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = bus.op[1] & a_neg;
          cnt_d      = {CW{1'b0}};
          if (bus.op[1]) begin
            acc_d  = {{N{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{N{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          state_d = zero_div_d ? FIX : CALC;
        end else begin
          // mthi/mtlo only land when no operation is being launched.
          if (bus.hi_wen) hi_d = bus.wd;
          if (bus.lo_wen) lo_d = bus.wd;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) acc_d = {div_rem, acc_q[N-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[N-1:1]};
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_div_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*N){1'b0}};
      opnd_q     <= {N{1'b0}};
      is_div_q   <= 1'b0;
      zero_div_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= {N{1'b0}};
      lo_q       <= {N{1'b0}};
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      zero_div_q <= zero_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, priority and reset abort.
// Expected values follow MDU_SIGNED_EN when the bench is compiled with it.
module tb_mult_div_unit;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  mult_div_unit_if #(.N(32)) bus ();

  mult_div_unit #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Launch one operation and return the number of edges after the start edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    bus.start = 1'b1;
    bus.op    = o;
    bus.inA   = a;
    bus.inB   = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.inA   = $urandom;
    bus.inB   = $urandom;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_multu();
    int lat;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_at_done got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
  endtask

  // Called while done from the previous operation is still high.
  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp_hi;
`ifdef MDU_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_hi = 32'h0000_0006;
`endif
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_in_done_cycle got=%b exp=1", bus.done); end
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    n_cmp++; if (bus.hi !== exp_hi) begin n_err++; $display("FAIL mult_hi got=%h exp=%h", bus.hi, exp_hi); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got=%h exp=ffffffeb", bus.lo); end
  endtask

  task automatic test_divides();
    int lat;
    logic [31:0] exp_q, exp_r;
    run_op(2'b10, 32'd100, 32'd7, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    n_cmp++; if (bus.lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL divu_dbz got=%b exp=0", bus.div_by_zero); end
`ifdef MDU_SIGNED_EN
    exp_q = 32'hFFFF_FFFD; exp_r = 32'hFFFF_FFFF;
`else
    exp_q = 32'h7FFF_FFFC; exp_r = 32'h0000_0001;
`endif
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
    n_cmp++; if (bus.lo !== exp_q) begin n_err++; $display("FAIL div_neg_lo got=%h exp=%h", bus.lo, exp_q); end
    n_cmp++; if (bus.hi !== exp_r) begin n_err++; $display("FAIL div_neg_hi got=%h exp=%h", bus.hi, exp_r); end
`ifdef MDU_SIGNED_EN
    exp_q = 32'h8000_0000; exp_r = 32'h0000_0000;
`else
    exp_q = 32'h0000_0000; exp_r = 32'h8000_0000;
`endif
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_cmp++; if (bus.lo !== exp_q) begin n_err++; $display("FAIL div_ovf_lo got=%h exp=%h", bus.lo, exp_q); end
    n_cmp++; if (bus.hi !== exp_r) begin n_err++; $display("FAIL div_ovf_hi got=%h exp=%h", bus.hi, exp_r); end
  endtask

  task automatic test_div_by_zero();
    int lat;
    bus.hi_wen = 1'b1; bus.lo_wen = 1'b1; bus.wd = 32'h33;
    @(posedge clock); #1;
    n_cmp++; if (bus.hi !== 32'h33 || bus.lo !== 32'h33) begin n_err++; $display("FAIL mthi_mtlo_both got=%h/%h exp=33/33", bus.hi, bus.lo); end
    bus.lo_wen = 1'b0; bus.wd = 32'h11;
    @(posedge clock); #1;
    bus.hi_wen = 1'b0; bus.lo_wen = 1'b1; bus.wd = 32'h22;
    @(posedge clock); #1;
    bus.lo_wen = 1'b0;
    n_cmp++; if (bus.hi !== 32'h11) begin n_err++; $display("FAIL mthi got=%h exp=11", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h22) begin n_err++; $display("FAIL mtlo got=%h exp=22", bus.lo); end
    run_op(2'b10, 32'd5, 32'd0, lat);
    // done lands on the edge after the start edge: two clocks counting the start edge.
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_cmp++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
    n_cmp++; if (bus.hi !== 32'h11) begin n_err++; $display("FAIL dbz_hi got=%h exp=11", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h22) begin n_err++; $display("FAIL dbz_lo got=%h exp=22", bus.lo); end
  endtask

  task automatic test_busy_priority();
    int lat;
    logic [31:0] hi_before;
    hi_before = bus.hi;
    bus.start = 1'b1; bus.op = 2'b00; bus.inA = 32'd6; bus.inB = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clock); #1; lat++; end
    bus.start = 1'b1; bus.op = 2'b10; bus.inA = 32'd1; bus.inB = 32'd1;
    bus.hi_wen = 1'b1; bus.wd = 32'h0BAD;
    @(posedge clock); #1; lat++;
    bus.start = 1'b0; bus.hi_wen = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_mid_calc got=%b exp=1", bus.busy); end
    n_cmp++; if (bus.hi !== hi_before) begin n_err++; $display("FAIL mthi_while_busy got=%h exp=%h", bus.hi, hi_before); end
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL busy_op_latency got=%0d exp=33", lat); end
    n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin n_err++; $display("FAIL busy_op_result got=%h/%h exp=0/2a", bus.hi, bus.lo); end
    // start with lo_wen in IDLE: the launch wins and the write is lost.
    bus.start = 1'b1; bus.op = 2'b10; bus.inA = 32'd100; bus.inB = 32'd7;
    bus.lo_wen = 1'b1; bus.wd = 32'hDEAD;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.lo_wen = 1'b0;
    n_cmp++; if (bus.lo !== 32'd42) begin n_err++; $display("FAIL start_vs_mtlo got=%h exp=2a", bus.lo); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_err++; $display("FAIL start_vs_mtlo_result got=%h/%h exp=2/e", bus.hi, bus.lo); end
    @(posedge clock); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL no_queued_start got=%b/%b exp=0/0", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    bus.start = 1'b1; bus.op = 2'b00; bus.inA = 32'hFFFF_FFFF; bus.inB = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL abort_hi got=%h exp=0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL abort_lo got=%h exp=0", bus.lo); end
    @(posedge clock); #2;
    reset = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge clock); #1; if (bus.done === 1'b1) dones++; end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_err++; $display("FAIL abort_hilo_after got=%h/%h exp=0/0", bus.hi, bus.lo); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.inA = '0; bus.inB = '0;
    bus.hi_wen = 1'b0; bus.lo_wen = 1'b0; bus.wd = '0;
    test_reset();
    test_multu();
    test_back_to_back();
    test_divides();
    test_div_by_zero();
    test_busy_priority();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit holding the MIPS HI/LO registers. It sits directly downstream of the register file: it consumes the two read-port values (rdA, rdB) for mult, multu, div and divu. It produces HI/LO for mfhi/mflo, and accepts mthi/mtlo writes. The main decoder stalls the core on `busy`.

## Interface
- `N`, 32, operand width; HI and LO are each N bits.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  00 multu, 01 mult, 10 divu, 11 div.
- `inA`  in  N  rs operand (multiplicand / dividend).
- `inB`  in  N  rt operand (multiplier / divisor).
- `hi_wen`  in  1  mthi write enable.
- `lo_wen`  in  1  mtlo write enable.
- `wd`  in  N  mthi/mtlo data.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO update with a result.
- `div_by_zero`  out  1  valid with `done`; 1 if divide with inB == 0.
- `hi`  out  N  HI register.
- `lo`  out  N  LO register.

## Operation
- **Reset values:** state IDLE; `busy`, `done` and `div_by_zero` are 0; `hi` and `lo` are 0; iteration counter is 0.
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start` = 1: latch the operand magnitudes and result signs, clear the accumulator, set counter = 0.
  - Then go to CALC, or directly to FIX if op is a divide and inB == 0.
- **CALC:** one iteration per clock, N iterations in total.
  - Multiply: shift-add over a 2N-bit product.
  - Divide: restoring, one quotient bit per clock.
  - Counter increments each clock; leave for FIX when counter == N-1.
- **FIX:**
  - Apply sign correction.
  - Write HI/LO, pulse `done`, return to IDLE.
- **Result mapping:**
  - Multiply: {hi, lo} = 2N-bit product.
  - Divide: lo = quotient, hi = remainder.
- **Signed rules:**
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - The mult product is exact over 2N bits.
- **Overflow:** div of 0x80000000 by 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wraps, no flag).
- **Divide by zero:**
  - HI/LO are left unchanged; `div_by_zero` = 1 together with `done`.
  - Latency is 2 clocks.
- **mthi/mtlo:**
  - Honoured only in IDLE and only when `start` = 0.
  - `start` takes priority; a simultaneous write is dropped.
  - Writes while busy are dropped.
  - hi_wen and lo_wen may both be asserted and both apply.
- **Start while busy:** ignored. Operands are captured at start, so inA/inB may change afterwards.

## Timing
- Edge E0: samples `start` in IDLE. `busy` is high from after E0.
- Edges E1..EN: the N CALC iterations.
- Edge E(N+1): FIX writes HI/LO. From this edge to the next, `done` = 1 and `busy` = 0.
- Latency: N+1 clocks from the start edge to the result, which is 33 clocks for N = 32.
- Back-to-back operations: a new `start` is accepted in the same cycle `done` is high.
- `hi`/`lo` change only at the FIX edge or at an mthi/mtlo edge; they are never partially updated during CALC.
- Reset asserted mid-operation: abort immediately and restore the reset values. No `done` is generated.

## Configuration
- Macro `MDU_SIGNED_EN`.
- **Defined:** op[0] selects signed mult/div, with magnitude conversion and FIX sign correction as above.
- **Undefined:**
  - op[0] is ignored; every operation is unsigned and FIX performs no correction.
  - Result timing is identical.

## Test plan
- **multu:** 0xFFFFFFFF × 0xFFFFFFFF → at 33 clocks `done` = 1, hi = 0xFFFFFFFE, lo = 0x00000001.
- **mult (signed):** −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Without `MDU_SIGNED_EN` → hi = 0x00000006, lo = 0xFFFFFFEB.
- **Divides:**
  - divu 100 / 7 → lo = 14, hi = 2.
  - div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** preload hi = 0x11, lo = 0x22 via mthi/mtlo, then divu 5 / 0 → `done` and `div_by_zero` 2 clocks after start, hi = 0x11, lo = 0x22.
- **Busy and priority:** a second `start` and an mthi during CALC are ignored, and the first result is unchanged. `start` together with lo_wen in IDLE → the write is dropped.
- **Reset mid-operation:** pull `reset` low at CALC iteration 10 → `busy`, `hi` and `lo` are immediately 0, and no `done` follows.
